// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int BUF_W      = NUM_DIGITS * DIGIT_W;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } slot_state_t;

  // Active-low one-hot anode pattern for the given digit index.
  function automatic logic [NUM_DIGITS-1:0] anode_select(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter and digit index for the display scan; flags slot/frame wrap and blanking.
module seg_slot_timer
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx,
  output logic             slot_wrap,
  output logic             frame_wrap,
  output logic             in_blank
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] count_reg, count_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      idx_reg   <= '0;
    end else begin
      count_reg <= count_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    count_next = count_reg + CNT_W'(1);
    idx_next   = idx_reg;
    if (slot_wrap) begin
      count_next = '0;
      idx_next   = idx_reg + IDX_W'(1);
    end
  end

  assign slot_wrap  = (count_reg == CNT_LAST);
  assign frame_wrap = slot_wrap && (idx_reg == IDX_LAST);
  assign in_blank   = (count_reg < BLANK_END);
  assign idx        = idx_reg;

endmodule

// File: rtl/seg_scan_controller.sv
// 4-digit 7-segment scan sequencer: byte handshake, frame-synchronous buffer commit, anode/nibble decode.
// Optional SEG_LEADING_ZERO_BLANK_EN suppresses leading-zero digits (idx0 always shown).
module seg_scan_controller
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [DIGIT_W-1:0]    digit,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  logic [IDX_W-1:0] idx;
  logic             slot_wrap_unused;
  logic             frame_wrap;
  logic             in_blank;

  seg_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .slot_wrap  (slot_wrap_unused),
    .frame_wrap (frame_wrap),
    .in_blank   (in_blank)
  );

  logic             pending_reg, pending_next;
  logic [7:0]       pend_byte_reg, pend_byte_next;
  logic [BUF_W-1:0] buffer_reg, buffer_next;
  logic             live_reg;
  logic             first_reg;
  logic             accept;
  logic             commit;
  slot_state_t      state;
  logic             drive_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg   <= 1'b0;
      pend_byte_reg <= '0;
      buffer_reg    <= '0;
      live_reg      <= 1'b0;
      first_reg     <= 1'b1;
    end else begin
      pending_reg   <= pending_next;
      pend_byte_reg <= pend_byte_next;
      buffer_reg    <= buffer_next;
      live_reg      <= 1'b1;
      first_reg     <= frame_wrap;
    end
  end

  // A held byte only reaches the display on the frame-wrap edge, so a frame never tears.
  always_comb begin
    accept         = data_valid && !pending_reg;
    commit         = frame_wrap && pending_reg;
    pending_next   = pending_reg;
    pend_byte_next = pend_byte_reg;
    buffer_next    = buffer_reg;
    if (commit) begin
      buffer_next  = {buffer_reg[BUF_W-9:0], pend_byte_reg};
      pending_next = 1'b0;
    end else if (accept) begin
      pend_byte_next = data_in;
      pending_next   = 1'b1;
    end
  end

  logic [DIGIT_W-1:0] nibble [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
    assign nibble[gi] = buffer_reg[gi*DIGIT_W +: DIGIT_W];
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // upper_zero[k]: nibbles k..top are all zero, so digit k is a leading zero.
  logic [NUM_DIGITS-1:0] upper_zero;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lead_zero
    assign upper_zero[gi] = (buffer_reg[BUF_W-1:gi*DIGIT_W] == '0);
  end
`endif

  // The cycle straight after reset is forced blank so an stays off even with BLANK_CYCLES=0.
  always_comb begin
    state = (in_blank || !live_reg) ? S_BLANK : S_DRIVE;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    drive_ok = (idx == '0) || !upper_zero[idx];
`else
    drive_ok = 1'b1;
`endif
    an    = ANODE_OFF;
    digit = nibble[idx];
    if (state == S_DRIVE && drive_ok) begin
      an = anode_select(idx);
    end
  end

  assign data_ready = !pending_reg;
  assign frame_tick = first_reg && !rst;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_controller;

  localparam int M_NORM = 0;
  localparam int M_HOLD = 1;
  localparam int M_SKIP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic [3:0] digit;
  logic [3:0] an;
  logic       frame_tick;

  typedef struct {
    logic [3:0] an;
    logic [3:0] digit;
    logic       tick;
    logic       rdy;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_no = 0;

  seg_scan_controller #(
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .digit      (digit),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Hand rule: slot = k%8, idx = (k/8)%4; first two cycles of a slot blank.
  function automatic logic [3:0] exp_an(input int k, input logic [15:0] b);
    int id;
    logic [15:0] upper;
    id = (k / 8) % 4;
    upper = b >> (4 * id);
    if ((k % 8) < 2) return 4'hF;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (id > 0 && upper == 16'h0) return 4'hF;
`endif
    return ~(4'b0001 << id);
  endfunction

  function automatic logic [3:0] exp_digit(input int k, input logic [15:0] b);
    logic [15:0] s;
    s = b >> (4 * ((k / 8) % 4));
    return s[3:0];
  endfunction

  task automatic step(input logic r_in, input int mode, input logic v, input logic [7:0] d,
                      input int k, input logic [15:0] b, input logic rdy);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r_in;
    data_valid = v;
    data_in = d;
    cyc_no++;
    if (mode == M_HOLD) begin
      e = '{an: 4'hF, digit: 4'h0, tick: 1'b0, rdy: 1'b1, cyc: cyc_no};
      q.push_back(e);
    end else if (mode == M_NORM) begin
      e = '{an: exp_an(k, b), digit: exp_digit(k, b), tick: ((k % 32) == 0) && !r_in,
            rdy: rdy, cyc: cyc_no};
      q.push_back(e);
    end
  endtask

  // Monitor: compares whatever the stimulus queued for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (an !== e.an || digit !== e.digit || frame_tick !== e.tick || data_ready !== e.rdy) begin
          bad++;
          $display("FAIL outputs cyc=%0d an got=%b exp=%b digit got=%h exp=%h tick got=%b exp=%b ready got=%b exp=%b",
                   e.cyc, an, e.an, digit, e.digit, frame_tick, e.tick, data_ready, e.rdy);
        end else begin
          $display("ok cyc=%0d an=%b digit=%h tick=%b ready=%b", e.cyc, an, digit, frame_tick, data_ready);
        end
      end
    end
  end

  initial begin
    logic       v;
    logic [7:0] d;
    logic [15:0] b;
    logic       rdy;

    // Reset hold, then idle scan across one full frame plus the next frame start.
    repeat (3) step(1'b1, M_HOLD, 1'b0, 8'h00, 0, 16'h0, 1'b1);
    for (int k = 0; k < 40; k++) step(1'b0, M_NORM, 1'b0, 8'h00, k, 16'h0000, 1'b1);

    // 0xA5 offered at cycle 5, shown from the next frame.
    step(1'b1, M_SKIP, 1'b0, 8'h00, 0, 16'h0, 1'b1);
    repeat (2) step(1'b1, M_HOLD, 1'b0, 8'h00, 0, 16'h0, 1'b1);
    for (int k = 0; k < 48; k++) begin
      b   = (k >= 32) ? 16'h00A5 : 16'h0000;
      rdy = (k <= 5) || (k >= 32);
      step(1'b0, M_NORM, k == 5, 8'hA5, k, b, rdy);
    end

    // 0x12 then back-pressured 0x34, a pending 0x56, and reset at cycle 77.
    step(1'b1, M_SKIP, 1'b0, 8'h00, 0, 16'h0, 1'b1);
    repeat (2) step(1'b1, M_HOLD, 1'b0, 8'h00, 0, 16'h0, 1'b1);
    for (int k = 0; k < 78; k++) begin
      v   = (k >= 3 && k <= 32) || (k == 66);
      d   = (k == 3) ? 8'h12 : ((k <= 32) ? 8'h34 : 8'h56);
      b   = (k >= 64) ? 16'h1234 : ((k >= 32) ? 16'h0012 : 16'h0000);
      rdy = (k <= 3) || (k == 32) || (k >= 64 && k <= 66);
      step(k == 77, M_NORM, v, d, k, b, rdy);
    end
    for (int k = 0; k < 40; k++) step(1'b0, M_NORM, 1'b0, 8'h00, k, 16'h0000, 1'b1);

    repeat (2) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
